// File: rtl/seq_det_sched_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_sched_pkg
// Shared types and helpers for the two-requester serial pattern scheduler.
//   state_e    : scheduler FSM state encoding
//   cnt_width  : width needed to hold a hit count for a word of 'width' bits
// -----------------------------------------------------------------------------
package seq_det_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // A word of 'width' bits can hold at most width-3 hits, so width+1 values
  // is a comfortable, simple bound for the count field.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_det_sched_arb.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous, active-low reset
//   req     in   [1:0] request vector
//   advance in   the current grant is consumed; remember who was served
//   gnt     out  [1:0] one-hot grant (combinational)
//   last_q  out  index of the requester granted last (reset: 1, so req0 wins)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       last_q
);

  logic last_d;

  // Grant selection: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer update: record the served requester only when a grant is consumed.
  always_comb begin
    if (advance && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// -----------------------------------------------------------------------------
// seq_det_sched
// Shares one external two-pattern serial detector (0110 / 0111) between two
// requesters. A granted word is cleared into the detector, shifted MSB-first,
// and the hits seen for that word are returned on a valid/ready result port.
// Ports:
//   clk, reset                 clock / async active-low reset
//   reqN_valid/data/ready      requester N word handshake (ready pulses on accept)
//   det_rst, det_din           clear and serial bit to the detector
//   det_0110, det_0111         detector flags (DET_LAT cycles after det_din)
//   res_valid/ready            result handshake
//   res_id, res_cnt_0110/0111  owner and hit counts of the finished word
//   busy                       high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int DET_LAT = 1,
  localparam int CW      = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             det_rst,
  output logic             det_din,
  input  logic             det_0110,
  input  logic             det_0111,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [CW-1:0]    res_cnt_0110,
  output logic [CW-1:0]    res_cnt_0111,
  output logic             busy
);

  // One counter indexes SHIFT cycles 0..WIDTH-1 and then DRAIN cycles
  // WIDTH..WIDTH+DET_LAT-1, which makes the sampling window a single compare.
  localparam int BCW = $clog2(WIDTH + DET_LAT + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    cnt_0110_q, cnt_0110_d;
  logic [CW-1:0]    cnt_0111_q, cnt_0111_d;
  logic             det_rst_q, det_rst_d;
  logic             det_din_q, det_din_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [CW-1:0]    res_cnt_0110_q, res_cnt_0110_d;
  logic [CW-1:0]    res_cnt_0111_q, res_cnt_0111_d;
  logic             busy_q, busy_d;

  logic [1:0]       gnt;
  logic             arb_last;
  logic             accept;
  logic             sample_en;
  logic             last_bit;
  logic             last_drain;

  assign accept     = (state_q == ST_IDLE) && (gnt != 2'b00);
  // Flags lag det_din by DET_LAT cycles, so the first DET_LAT shift cycles
  // still show the response to the cleared state and are skipped.
  assign sample_en  = (bit_cnt_q >= BCW'(DET_LAT));
  assign last_bit   = (bit_cnt_q == BCW'(WIDTH - 1));
  assign last_drain = (bit_cnt_q == BCW'(WIDTH + DET_LAT - 1));

  // Gating with reset keeps the ready pulses low while reset is asserted.
  assign req0_ready = reset && accept && gnt[0];
  assign req1_ready = reset && accept && gnt[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt),
    .last_q  (arb_last)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d        = state_q;
    sh_d           = sh_q;
    bit_cnt_d      = bit_cnt_q;
    cnt_0110_d     = cnt_0110_q;
    cnt_0111_d     = cnt_0111_q;
    det_din_d      = 1'b0;
    res_id_d       = res_id_q;
    res_cnt_0110_d = res_cnt_0110_q;
    res_cnt_0111_d = res_cnt_0111_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CLEAR;
          sh_d    = gnt[1] ? req1_data : req0_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d    = ST_SHIFT;
        bit_cnt_d  = {BCW{1'b0}};
        cnt_0110_d = {CW{1'b0}};
        cnt_0111_d = {CW{1'b0}};
        // Present the MSB in the first SHIFT cycle.
        det_din_d  = sh_q[WIDTH-1];
        sh_d       = {sh_q[WIDTH-2:0], 1'b0};
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + BCW'(1);
        if (sample_en) begin
          cnt_0110_d = cnt_0110_q + CW'(det_0110);
          cnt_0111_d = cnt_0111_q + CW'(det_0111);
        end else begin
          cnt_0110_d = cnt_0110_q;
          cnt_0111_d = cnt_0111_q;
        end
        if (last_bit) begin
          state_d = (DET_LAT > 0) ? ST_DRAIN : ST_DONE;
        end else begin
          state_d   = ST_SHIFT;
          det_din_d = sh_q[WIDTH-1];
          sh_d      = {sh_q[WIDTH-2:0], 1'b0};
        end
      end
      ST_DRAIN: begin
        bit_cnt_d  = bit_cnt_q + BCW'(1);
        cnt_0110_d = cnt_0110_q + CW'(det_0110);
        cnt_0111_d = cnt_0111_q + CW'(det_0111);
        if (last_drain) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    det_rst_d   = (state_d == ST_CLEAR);
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);

    // Capture the result once on DONE entry; it then holds under back-pressure.
    // The arbiter pointer still names the owner, as no new grant can occur yet.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      res_id_d       = arb_last;
      res_cnt_0110_d = cnt_0110_d;
      res_cnt_0111_d = cnt_0111_d;
    end else begin
      res_id_d       = res_id_q;
      res_cnt_0110_d = res_cnt_0110_q;
      res_cnt_0111_d = res_cnt_0111_q;
    end
  end

  // FSM, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      sh_q           <= {WIDTH{1'b0}};
      bit_cnt_q      <= {BCW{1'b0}};
      cnt_0110_q     <= {CW{1'b0}};
      cnt_0111_q     <= {CW{1'b0}};
      det_rst_q      <= 1'b0;
      det_din_q      <= 1'b0;
      res_valid_q    <= 1'b0;
      res_id_q       <= 1'b0;
      res_cnt_0110_q <= {CW{1'b0}};
      res_cnt_0111_q <= {CW{1'b0}};
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_q           <= sh_d;
      bit_cnt_q      <= bit_cnt_d;
      cnt_0110_q     <= cnt_0110_d;
      cnt_0111_q     <= cnt_0111_d;
      det_rst_q      <= det_rst_d;
      det_din_q      <= det_din_d;
      res_valid_q    <= res_valid_d;
      res_id_q       <= res_id_d;
      res_cnt_0110_q <= res_cnt_0110_d;
      res_cnt_0111_q <= res_cnt_0111_d;
      busy_q         <= busy_d;
    end
  end

  assign det_rst      = det_rst_q;
  assign det_din      = det_din_q;
  assign res_valid    = res_valid_q;
  assign res_id       = res_id_q;
  assign res_cnt_0110 = res_cnt_0110_q;
  assign res_cnt_0111 = res_cnt_0111_q;
  assign busy         = busy_q;

endmodule
